// File: rtl/tpu_pkg.sv
// Shared TPU definitions: state encoding, Float8 widths and sign-magnitude compare.
package tpu_pkg;

   localparam int NUM_CLASSES = 10;
   localparam int VEC_LEN     = 128;
   localparam int F8_W        = 8;
   localparam int ACC_W       = 15;
   localparam int WORD_W      = VEC_LEN * F8_W;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_A_REQ = 4'd1,
      S_A_GET = 4'd2,
      S_W_REQ = 4'd3,
      S_W_GET = 4'd4,
      S_MAC   = 4'd5,
      S_ADD   = 4'd6,
      S_CMP   = 4'd7,
      S_WB    = 4'd8,
      S_DONE  = 4'd9
   } state_t;

   // -0 is folded onto +0 so the two compare equal.
   function automatic logic sm_gt(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
      logic a_neg;
      logic b_neg;
      a_neg = a[ACC_W-1] && (a[ACC_W-2:0] != '0);
      b_neg = b[ACC_W-1] && (b[ACC_W-2:0] != '0);
      if (a_neg != b_neg) return b_neg;
      if (!a_neg)         return a[ACC_W-2:0] > b[ACC_W-2:0];
      return a[ACC_W-2:0] < b[ACC_W-2:0];
   endfunction

endpackage

// File: rtl/full_connect2_if.sv
// ROM/RAM/MultAdder bus bundle of full_connect2; master is the classifier side.
interface full_connect2_if;
   import tpu_pkg::*;

   logic [WORD_W-1:0] data_from_rom;
   logic [WORD_W-1:0] data_from_ram;
   logic [ACC_W-1:0]  data_from_MultAdder;
   logic              overflow_from_MultAdder;
   logic [31:0]       addr_to_rom;
   logic [31:0]       addr_to_ram;
   logic [WORD_W-1:0] opr1_to_MultAdder;
   logic [WORD_W-1:0] opr2_to_MultAdder;
   logic [WORD_W-1:0] data_to_ram;
   logic              wr_en_ram;

   modport master (
      input  data_from_rom, data_from_ram, data_from_MultAdder, overflow_from_MultAdder,
      output addr_to_rom, addr_to_ram, opr1_to_MultAdder, opr2_to_MultAdder,
             data_to_ram, wr_en_ram
   );

   modport slave (
      output data_from_rom, data_from_ram, data_from_MultAdder, overflow_from_MultAdder,
      input  addr_to_rom, addr_to_ram, opr1_to_MultAdder, opr2_to_MultAdder,
             data_to_ram, wr_en_ram
   );

endinterface

// File: rtl/Float8Adder.sv
// 15-bit sign-magnitude adder; same-sign sums saturate and flag overflow.
module Float8Adder
   import tpu_pkg::*;
(
   input  logic [ACC_W-1:0] i_a,
   input  logic [ACC_W-1:0] i_b,
   output logic [ACC_W-1:0] o_sum,
   output logic             o_ovf
);

   logic [ACC_W-2:0] w_a_mag;
   logic [ACC_W-2:0] w_b_mag;
   logic [ACC_W-1:0] w_mag_add;

   assign w_a_mag   = i_a[ACC_W-2:0];
   assign w_b_mag   = i_b[ACC_W-2:0];
   assign w_mag_add = {1'b0, w_a_mag} + {1'b0, w_b_mag};

   always_comb begin
      o_sum = '0;
      o_ovf = 1'b0;
      if (i_a[ACC_W-1] == i_b[ACC_W-1]) begin
         o_ovf = w_mag_add[ACC_W-1];
         o_sum = {i_a[ACC_W-1], w_mag_add[ACC_W-1] ? {(ACC_W-1){1'b1}} : w_mag_add[ACC_W-2:0]};
      end else if (w_a_mag >= w_b_mag) begin
         o_sum = {i_a[ACC_W-1], w_a_mag - w_b_mag};
      end else begin
         o_sum = {i_b[ACC_W-1], w_b_mag - w_a_mag};
      end
      if (o_sum[ACC_W-2:0] == '0) o_sum[ACC_W-1] = 1'b0;
   end

endmodule

// File: rtl/full_connect2.sv
// Output layer: 10 biased dot products, argmax digit and sticky overflow.
// Optional score writeback to RAM is enabled by defining FC2_SCORE_WRITEBACK_EN.
//
// state  | meaning
// IDLE   | wait for ena && start
// A_REQ  | address activations (RAM) and bias word (ROM)
// A_GET  | latch activations and biases
// W_REQ  | address weight row r
// W_GET  | present activations/weights to the MultAdder
// MAC    | capture dot product and bias as adder inputs
// ADD    | latch biased score of row r
// CMP    | update argmax, advance row
// WB     | one-cycle score write to RAM
// DONE   | result valid until start drops
module full_connect2
   import tpu_pkg::*;
#(
   parameter logic [31:0] rom_addr_base   = 32'h0000_3000,
   parameter logic [31:0] ram_addr_base   = 32'h0000_1000,
   parameter logic [31:0] bias_addr_base  = 32'h0000_4000,
   parameter logic [31:0] score_addr_base = 32'h0000_5000
)(
   input  logic             clk,
   input  logic             iRst_n,
   input  logic             ena,
   input  logic             start,
   full_connect2_if.master  bus,
   output logic [3:0]       digit,
   output logic             overflow,
   output logic             done
);

   state_t                        r_state;
   state_t                        w_next;
   logic [3:0]                    r_row;
   logic [WORD_W-1:0]             r_act;
   logic [NUM_CLASSES*F8_W-1:0]   r_bias;
   logic [ACC_W-1:0]              r_add_a;
   logic [ACC_W-1:0]              r_add_b;
   logic [ACC_W-1:0]              r_score;
   logic [ACC_W-1:0]              r_best;
   logic [ACC_W-1:0]              w_sum;
   logic                          w_add_ovf;
   logic                          w_last;
   logic                          r_ovf;
   logic [3:0]                    r_digit;
`ifdef FC2_SCORE_WRITEBACK_EN
   logic [NUM_CLASSES*F8_W-1:0]   r_wb;
`endif

   assign w_last   = (r_row == 4'(NUM_CLASSES - 1));
   assign digit    = r_digit;
   assign overflow = r_ovf;
   assign done     = (r_state == S_DONE);

   Float8Adder u_bias_add (
      .i_a   (r_add_a),
      .i_b   (r_add_b),
      .o_sum (w_sum),
      .o_ovf (w_add_ovf)
   );

   always_ff @(posedge clk or negedge iRst_n) begin
      if (!iRst_n)  r_state <= S_IDLE;
      else if (ena) r_state <= w_next;
   end

   always_comb begin
      w_next                  = r_state;
      bus.addr_to_rom         = '0;
      bus.addr_to_ram         = '0;
      bus.opr1_to_MultAdder   = '0;
      bus.opr2_to_MultAdder   = '0;
      bus.data_to_ram         = '0;
      bus.wr_en_ram           = 1'b0;
      case (r_state)
         S_IDLE:  if (start) w_next = S_A_REQ;
         S_A_REQ: w_next = S_A_GET;
         S_A_GET: w_next = S_W_REQ;
         S_W_REQ: w_next = S_W_GET;
         S_W_GET: w_next = S_MAC;
         S_MAC:   w_next = S_ADD;
         S_ADD:   w_next = S_CMP;
`ifdef FC2_SCORE_WRITEBACK_EN
         S_CMP:   w_next = w_last ? S_WB : S_W_REQ;
`else
         S_CMP:   w_next = w_last ? S_DONE : S_W_REQ;
`endif
         S_WB:    w_next = S_DONE;
         S_DONE:  if (!start) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      // Buses are released (driven 0) whenever the block does not own them.
      if (ena) begin
         case (r_state)
            S_A_REQ: begin
               bus.addr_to_ram = ram_addr_base;
               bus.addr_to_rom = bias_addr_base;
            end
            S_W_REQ: bus.addr_to_rom = rom_addr_base + 32'(r_row);
            S_W_GET: begin
               bus.opr1_to_MultAdder = r_act;
               bus.opr2_to_MultAdder = bus.data_from_rom;
            end
            S_WB: begin
               bus.addr_to_ram = score_addr_base;
`ifdef FC2_SCORE_WRITEBACK_EN
               bus.data_to_ram = {{(WORD_W - NUM_CLASSES*F8_W){1'b0}}, r_wb};
               bus.wr_en_ram   = 1'b1;
`endif
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_row   <= '0;
         r_act   <= '0;
         r_bias  <= '0;
         r_add_a <= '0;
         r_add_b <= '0;
         r_score <= '0;
         r_best  <= '0;
         r_ovf   <= 1'b0;
         r_digit <= '0;
`ifdef FC2_SCORE_WRITEBACK_EN
         r_wb    <= '0;
`endif
      end else if (ena) begin
         case (r_state)
            S_IDLE: if (start) begin
               r_row <= '0;
               r_ovf <= 1'b0;
            end
            S_A_GET: begin
               r_act  <= bus.data_from_ram;
               r_bias <= bus.data_from_rom[NUM_CLASSES*F8_W-1:0];
            end
            S_MAC: begin
               r_add_a <= bus.data_from_MultAdder;
               r_add_b <= {r_bias[F8_W*r_row +: F8_W], 7'b0};
               r_ovf   <= r_ovf | bus.overflow_from_MultAdder;
            end
            S_ADD: begin
               r_score <= w_sum;
               r_ovf   <= r_ovf | w_add_ovf;
`ifdef FC2_SCORE_WRITEBACK_EN
               r_wb[F8_W*r_row +: F8_W] <= w_sum[ACC_W-1:7];
`endif
            end
            S_CMP: begin
               // Strictly-greater replacement keeps the lowest index on ties.
               if (r_row == '0 || sm_gt(r_score, r_best)) begin
                  r_best  <= r_score;
                  r_digit <= r_row;
               end
               if (!w_last) r_row <= r_row + 4'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_full_connect2.sv
// Directed bench for full_connect2 with behavioural ROM/RAM/MultAdder stubs.
module tb_full_connect2;
   import tpu_pkg::*;

   localparam logic [31:0] ROM_BASE   = 32'h0000_3000;
   localparam logic [31:0] RAM_BASE   = 32'h0000_1000;
   localparam logic [31:0] BIAS_BASE  = 32'h0000_4000;
   localparam logic [31:0] SCORE_BASE = 32'h0000_5000;
`ifdef FC2_SCORE_WRITEBACK_EN
   localparam int LAT = 53;
`else
   localparam int LAT = 52;
`endif

   logic        clk = 1'b0;
   logic        iRst_n;
   logic        ena;
   logic        start;
   logic [3:0]  digit;
   logic        overflow;
   logic        done;

   logic [ACC_W-1:0]  ma_tab [NUM_CLASSES];
   logic [7:0]        bias_tab [NUM_CLASSES];
   logic [NUM_CLASSES-1:0] ov_mask;
   logic [WORD_W-1:0] act_word;
   logic [WORD_W-1:0] rom_q, ram_q, wr_data;
   logic [ACC_W-1:0]  ma_q;
   logic              ov_q;
   logic [31:0]       wr_addr;
   int                wr_cnt = 0;
   int                n_checks = 0;
   int                n_err = 0;

   full_connect2_if bus();

   full_connect2 dut (
      .clk      (clk),
      .iRst_n   (iRst_n),
      .ena      (ena),
      .start    (start),
      .bus      (bus),
      .digit    (digit),
      .overflow (overflow),
      .done     (done)
   );

   always #5 clk = ~clk;

   assign bus.data_from_rom           = rom_q;
   assign bus.data_from_ram           = ram_q;
   assign bus.data_from_MultAdder     = ma_q;
   assign bus.overflow_from_MultAdder = ov_q;

   // Weight row r carries tag r+1 in byte 0 so the MultAdder stub knows the row.
   function automatic logic [WORD_W-1:0] rom_word(input logic [31:0] a);
      logic [WORD_W-1:0] w;
      w = '0;
      if (a == BIAS_BASE) begin
         for (int i = 0; i < NUM_CLASSES; i++) w[8*i +: 8] = bias_tab[i];
      end else if (a >= ROM_BASE && a < ROM_BASE + 32'd10) begin
         w[7:0] = 8'(a - ROM_BASE + 32'd1);
      end
      return w;
   endfunction

   always @(posedge clk) begin
      int t;
      rom_q <= rom_word(bus.addr_to_rom);
      ram_q <= (bus.addr_to_ram == RAM_BASE) ? act_word : '0;
      t = int'(bus.opr2_to_MultAdder[7:0]);
      if (t >= 1 && t <= NUM_CLASSES) begin
         ma_q <= ma_tab[t-1];
         ov_q <= ov_mask[t-1];
      end else begin
         ma_q <= '0;
         ov_q <= 1'b0;
      end
      if (bus.wr_en_ram === 1'b1) begin
         wr_cnt  <= wr_cnt + 1;
         wr_addr <= bus.addr_to_ram;
         wr_data <= bus.data_to_ram;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_tabs(input logic [ACC_W-1:0] dflt);
      for (int i = 0; i < NUM_CLASSES; i++) begin
         ma_tab[i]   = dflt;
         bias_tab[i] = 8'h00;
      end
      ov_mask = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Cycle 0 is the edge that samples start; done is expected exp_lat edges later.
   task automatic do_run(input string tag, input logic [3:0] exp_digit, input logic exp_ovf);
      int  n;
      bit  got;
      n   = 0;
      got = 0;
      start = 1'b1;
      while (n < 200 && !got) begin
         step();
         n++;
         if (n == 1) begin
            check({tag, "_ram_addr"}, bus.addr_to_ram, RAM_BASE);
            check({tag, "_bias_addr"}, bus.addr_to_rom, BIAS_BASE);
            check({tag, "_ovf_clr"}, 32'(overflow), 32'd0);
         end
         if (n == 3) check({tag, "_w0_addr"}, bus.addr_to_rom, ROM_BASE);
         if (n == 4) check({tag, "_opr1"}, 32'(bus.opr1_to_MultAdder === act_word), 32'd1);
         if (done === 1'b1) got = 1;
      end
      check({tag, "_done_seen"}, 32'(got), 32'd1);
      check({tag, "_latency"}, 32'(n - 1), 32'(LAT));
      check({tag, "_digit"}, 32'(digit), 32'(exp_digit));
      check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
      repeat (3) step();
      check({tag, "_hold_done"}, 32'(done), 32'd1);
      check({tag, "_hold_digit"}, 32'(digit), 32'(exp_digit));
      start = 1'b0;
      step();
      check({tag, "_idle"}, 32'(done), 32'd0);
      check({tag, "_ovf_sticky"}, 32'(overflow), 32'(exp_ovf));
   endtask

   initial begin
      int n;
      int wr_before;
      iRst_n = 1'b0;
      ena    = 1'b1;
      start  = 1'b0;
      for (int i = 0; i < VEC_LEN; i++) act_word[8*i +: 8] = 8'(i * 3 + 1);
      set_tabs(15'h0010);
      #12;
      check("rst_done", 32'(done), 32'd0);
      check("rst_digit", 32'(digit), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_rom_addr", bus.addr_to_rom, 32'd0);
      check("rst_ram_addr", bus.addr_to_ram, 32'd0);
      check("rst_wr_en", 32'(bus.wr_en_ram), 32'd0);
      check("rst_opr2_zero", 32'(bus.opr2_to_MultAdder === '0), 32'd1);
      check("rst_data_zero", 32'(bus.data_to_ram === '0), 32'd1);
      step();
      iRst_n = 1'b1;
      step();

      // Row 3 largest
      set_tabs(15'h0010);
      ma_tab[3] = 15'h0100;
      do_run("max_row3", 4'd3, 1'b0);

      // All negative, row 7 least negative
      set_tabs(15'h4010);
      ma_tab[7] = 15'h4001;
      do_run("neg_row7", 4'd7, 1'b0);

      // Ties keep the lowest index
      set_tabs(15'h0020);
      do_run("tie", 4'd0, 1'b0);

      // MultAdder overflow on row 5 only; next run must clear it
      set_tabs(15'h0010);
      ma_tab[3]  = 15'h0100;
      ov_mask[5] = 1'b1;
      do_run("ma_ovf", 4'd3, 1'b1);
      ov_mask = '0;
      do_run("ovf_clear", 4'd3, 1'b0);

      // Biases: row 2 pushed negative, row 6 raised to 144
      set_tabs(15'h0010);
      ma_tab[2]   = 15'h0100;
      bias_tab[2] = 8'h83;
      bias_tab[6] = 8'h01;
      do_run("bias", 4'd6, 1'b0);

      // Bias add overflows on row 4
      set_tabs(15'h0010);
      ma_tab[4]   = 15'h3F80;
      bias_tab[4] = 8'h7F;
      do_run("add_ovf", 4'd4, 1'b1);

      // ena dropped for 5 cycles while in W_REQ of row 0
      set_tabs(15'h0010);
      ma_tab[3] = 15'h0100;
      start = 1'b1;
      n = 0;
      while (n < 200 && done !== 1'b1) begin
         step();
         n++;
         if (n == 3) ena = 1'b0;
         if (n == 5) check("ena_rom_addr0", bus.addr_to_rom, 32'd0);
         if (n == 8) ena = 1'b1;
      end
      check("ena_latency", 32'(n - 1), 32'(LAT + 5));
      check("ena_digit", 32'(digit), 32'd3);
      start = 1'b0;
      step();

      // Asynchronous reset mid-run, then a clean rerun
      set_tabs(15'h0010);
      ma_tab[1]  = 15'h0200;
      ov_mask[0] = 1'b1;
      start = 1'b1;
      repeat (20) step();
      check("pre_rst_digit", 32'(digit), 32'd1);
      check("pre_rst_ovf", 32'(overflow), 32'd1);
      #2 iRst_n = 1'b0;
      #1;
      check("arst_digit", 32'(digit), 32'd0);
      check("arst_ovf", 32'(overflow), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_rom_addr", bus.addr_to_rom, 32'd0);
      start = 1'b0;
      step();
      iRst_n = 1'b1;
      step();
      do_run("rerun", 4'd1, 1'b1);

`ifdef FC2_SCORE_WRITEBACK_EN
      set_tabs(15'h0000);
      for (int r = 0; r < NUM_CLASSES; r++) ma_tab[r] = 15'(r << 7);
      wr_before = wr_cnt;
      do_run("wb", 4'd9, 1'b0);
      check("wb_pulses", 32'(wr_cnt - wr_before), 32'd1);
      check("wb_addr", wr_addr, SCORE_BASE);
      check("wb_bytes_lo", wr_data[31:0], 32'h0302_0100);
      check("wb_bytes_mid", wr_data[63:32], 32'h0706_0504);
      check("wb_bytes_hi", 32'(wr_data[79:64]), 32'h0000_0908);
      check("wb_upper_zero", 32'(wr_data[WORD_W-1:80] === '0), 32'd1);
`else
      wr_before = 0;
      check("no_wb_pulses", 32'(wr_cnt - wr_before), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/full_connect2.md
# full_connect2

Output layer of the TPU digit classifier, directly downstream of `full_connect1`. On `start` it reads the 128 hidden activations that `full_connect1` wrote to RAM and computes 10 class scores. Each score is one 128-wide dot product from the shared MultAdder plus a per-class bias, added in a local `Float8Adder`. The block then reports the argmax digit (0–9) and a sticky overflow flag.

## Interface
Parameters:
- `rom_addr_base`, 32'h00003000, ROM word address of weight row 0; row r is at base+r.
- `ram_addr_base`, 32'h00001000, RAM word holding the 128 hidden activations, byte i = bits [8i+7:8i].
- `bias_addr_base`, 32'h00004000, ROM word holding the 10 biases, byte r = class r.
- `score_addr_base`, 32'h00005000, RAM word receiving the scores (only with `FC2_SCORE_WRITEBACK_EN`).

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `iRst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: block owns the ROM/RAM/MultAdder buses.
- `start` in 1: level; sampled only in IDLE; tied to `full_connect1` `done`.
- `data_from_rom` in 1024: ROM read data.
- `data_from_ram` in 1024: RAM read data.
- `data_from_MultAdder` in 15: dot-product result.
- `overflow_from_MultAdder` in 1: MultAdder overflow.
- `addr_to_rom` out 32: ROM read address.
- `addr_to_ram` out 32: RAM address.
- `opr1_to_MultAdder`, `opr2_to_MultAdder` out 1024 each: activation and weight vectors.
- `data_to_ram` out 1024: score write data.
- `wr_en_ram` out 1: one-cycle RAM write strobe.
- `digit` out 4: argmax class.
- `overflow` out 1: sticky overflow.
- `done` out 1: result valid.

## Operation
- Memory contract: an address registered at cycle N yields data sampled in the state at N+1.
- States and transitions:
  - IDLE: leaves to A_REQ when `ena && start`.
  - A_REQ: drives `addr_to_ram`=ram base and `addr_to_rom`=bias base. Next: A_GET.
  - A_GET: latches the activations and the bias word. Next: W_REQ.
  - W_REQ: drives `addr_to_rom`=rom base+r. Next: W_GET.
  - W_GET: drives opr1=activations and opr2=`data_from_rom`. Next: MAC.
  - MAC: adder inputs are the MultAdder result and {bias[r],7'b0}. Overflow ORs in `overflow_from_MultAdder`. Next: ADD.
  - ADD: latches score[r]=adder sum and ORs in adder overflow. Next: CMP.
  - CMP: updates the argmax. Next: W_REQ with r+1 if r<9, else WB (macro on) or DONE.
  - WB: drives `wr_en_ram`=1 for one cycle. Next: DONE.
  - DONE: `done`=1; `digit` and `overflow` held. Returns to IDLE when `start`=0.
- Number format: 15-bit sign-magnitude, bit14 = sign, [13:0] = magnitude.
- Compare order: −0 equals +0. Any positive beats any negative. Larger magnitude wins among positives; smaller magnitude wins among negatives.
- Argmax rule: row 0 initialises best; a later row replaces best only if strictly greater. Ties therefore keep the lowest index.
- `overflow` is cleared on leaving IDLE and is otherwise sticky. Overflowed sums still take part in the compare.
- `ena`=0 mid-run: state and counters freeze; addresses and operands are driven 0. Operation resumes at the frozen state when `ena` returns.
- Async reset at any point: goes to IDLE, with every output and counter set to 0.

## Timing
- Reset values of all outputs: 0.
- `start`→`done` latency: 2 + 10×5 = 52 cycles, or 53 with writeback.
- `done` asserts in the cycle after the last CMP or WB state.
- `digit` is stable whenever `done`=1.
- `start` held high during DONE does not restart the block. A new run needs `start` to go low, then high again.

## Configuration
- `FC2_SCORE_WRITEBACK_EN` defined:
  - WB state exists.
  - `data_to_ram` byte r = score[r][14:7], bytes 10–127 = 0.
  - `addr_to_ram`=score base with `wr_en_ram`=1 for exactly one cycle.
- Macro undefined:
  - WB is skipped.
  - `data_to_ram` and `wr_en_ram` are constant 0.

## Structure
- Shared package `tpu_pkg` holds:
  - the state encoding;
  - `NUM_CLASSES`=10, `VEC_LEN`=128;
  - the Float8 widths (8 stored bits, 15 accumulator bits);
  - a sign-magnitude greater-than function.
- Sub-module: one `Float8Adder` instance for the bias add; MultAdder stays external.

## Test plan
- MultAdder stub returns 15'h0010 for all rows except 15'h0100 on row 3; biases 0 → `digit`=3, `overflow`=0, `done` at cycle 52.
- All rows 15'h4010 (negative) except row 7 = 15'h4001 → `digit`=7 (least negative wins).
- All rows equal 15'h0020 → `digit`=0 (tie keeps lowest index).
- `overflow_from_MultAdder` pulsed on row 5 only → `overflow`=1 held through DONE; next `start` clears it.
- `iRst_n` low at cycle 20 → all outputs 0 immediately; rerun gives the correct digit.
- With the macro defined: row r score = r<<7 → one `wr_en_ram` pulse with `data_to_ram` bytes 0–9 = 0..9 and `digit`=9.
